// File: rtl/dual_branch_predictor_if.sv
// Fetch/Decode/Execute signal bundle between the core pipeline and the dual-slot branch predictor.
interface dual_branch_predictor_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pcF;
  logic                stallD;
  logic                flushD;
  logic                flushE;
  logic                branchE1;
  logic                branchE2;
  logic                takenBranchE1;
  logic                takenBranchE2;
  logic [PC_WIDTH-1:0] pcE1;
  logic [PC_WIDTH-1:0] pcE2;
  logic                predictionF1;
  logic                predictionF2;
  logic                predictionE1;
  logic                predictionE2;
  logic [15:0]         mispredictCount;

  modport master (
    output pcF, stallD, flushD, flushE,
    output branchE1, branchE2, takenBranchE1, takenBranchE2, pcE1, pcE2,
    input  predictionF1, predictionF2, predictionE1, predictionE2, mispredictCount
  );

  modport slave (
    input  pcF, stallD, flushD, flushE,
    input  branchE1, branchE2, takenBranchE1, takenBranchE2, pcE1, pcE2,
    output predictionF1, predictionF2, predictionE1, predictionE2, mispredictCount
  );
endinterface

// File: rtl/dual_branch_predictor.sv
// Two-slot bimodal predictor: shared 2-bit counter table, F->D->E prediction pipeline,
// and a saturating misprediction counter.
module dual_branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6
) (
  input logic                   clk,
  input logic                   rst,
  dual_branch_predictor_if.slave bp
);
  localparam int TableSize = 1 << INDEX_BITS;

  logic [1:0]            counterTable [TableSize];
  logic [INDEX_BITS-1:0] idxF1, idxF2, idxE1, idxE2;
  logic [1:0]            next1, base2, next2;
  logic                  predD1, predD2, predE1, predE2;
  logic                  mispredict1, mispredict2;
  logic [15:0]           count;
  logic [16:0]           countSum;

  function automatic logic [1:0] trainCounter(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

  assign idxF1 = bp.pcF[INDEX_BITS-1:0];
  assign idxF2 = INDEX_BITS'(bp.pcF + PC_WIDTH'(1));
  assign idxE1 = bp.pcE1[INDEX_BITS-1:0];
  assign idxE2 = bp.pcE2[INDEX_BITS-1:0];

  // Slot 2 trains on top of slot 1's result when both hit the same entry.
  always_comb begin
    next1 = trainCounter(counterTable[idxE1], bp.takenBranchE1);
    base2 = counterTable[idxE2];
    if (bp.branchE1 && (idxE1 == idxE2)) base2 = next1;
    next2 = trainCounter(base2, bp.takenBranchE2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TableSize; i++) counterTable[i] <= 2'b01;
    end else begin
      if (bp.branchE1) counterTable[idxE1] <= next1;
      if (bp.branchE2) counterTable[idxE2] <= next2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      predD1 <= 1'b0;
      predD2 <= 1'b0;
      predE1 <= 1'b0;
      predE2 <= 1'b0;
    end else begin
      if (bp.flushD) begin
        predD1 <= 1'b0;
        predD2 <= 1'b0;
      end else if (!bp.stallD) begin
        predD1 <= bp.predictionF1;
        predD2 <= bp.predictionF2;
      end
      if (bp.flushE) begin
        predE1 <= 1'b0;
        predE2 <= 1'b0;
      end else begin
        predE1 <= predD1;
        predE2 <= predD2;
      end
    end
  end

  assign mispredict1 = bp.branchE1 & (bp.takenBranchE1 ^ predE1);
  assign mispredict2 = bp.branchE2 & (bp.takenBranchE2 ^ predE2);
  assign countSum    = {1'b0, count} + {16'b0, mispredict1} + {16'b0, mispredict2};

  always_ff @(posedge clk) begin
    if (!rst) count <= 16'h0000;
    else      count <= countSum[16] ? 16'hFFFF : countSum[15:0];
  end

  assign bp.predictionF1    = counterTable[idxF1][1];
  assign bp.predictionF2    = counterTable[idxF2][1];
  assign bp.predictionE1    = predE1;
  assign bp.predictionE2    = predE2;
  assign bp.mispredictCount = count;
endmodule
